// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the instruction-sequencing control unit.
//   - op_e      : ALU / instruction op codes, also used as the ALU select
//   - state_e   : sequencer step encoding (T0 fetch, T1..T3 execute)
//   - field bit positions inside the 16-bit instruction word
//   - is_alu_op : true for the three-step arithmetic/logic instructions
// No ports (package).
// -----------------------------------------------------------------------------
package control_unit_pkg;

  localparam int DIN_W    = 16;  // instruction / immediate word width
  localparam int NUM_REGS = 8;   // general registers R0..R7
  localparam int SEL_W    = 3;   // register select field width
  localparam int OP_W     = 3;   // op field width

  // Instruction word fields: din[8:6]=op, din[5:3]=X, din[2:0]=Y.
  // Bits above OP_MSB carry no meaning and are never stored.
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;
  localparam int IR_W   = OP_MSB + 1;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NAN = 3'b010,
    OP_UD3 = 3'b011,  // undefined: completes in one step, writes nothing
    OP_OUT = 3'b100,
    OP_LDI = 3'b101,
    OP_UD6 = 3'b110,  // undefined: completes in one step, writes nothing
    OP_REP = 3'b111   // register copy; also the idle ALU select
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,  // fetch
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  function automatic logic is_alu_op(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAN);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
// Bundles the control unit's instruction input and datapath control outputs.
//   run       : start request (sampled in T0)
//   din[15:0] : instruction word in T0, immediate operand in T1
//   ir_load   : capture din into the instruction register
//   r_in      : one-hot register write enables R0..R7
//   r_out     : one-hot register bus drive selects R0..R7
//   a_in      : load ALU operand A from bus
//   g_in      : load ALU result register G
//   g_out     : drive G onto bus
//   din_out   : drive din onto bus
//   out_load  : load output port register from bus
//   op_select : ALU operation select
//   done      : one-cycle pulse in the final step of an instruction
// Modports: slave = control unit, master = datapath / stimulus side.
// -----------------------------------------------------------------------------
interface control_unit_if;
  import control_unit_pkg::*;

  logic                run;
  logic [DIN_W-1:0]    din;
  logic                ir_load;
  logic [NUM_REGS-1:0] r_in;
  logic [NUM_REGS-1:0] r_out;
  logic                a_in;
  logic                g_in;
  logic                g_out;
  logic                din_out;
  logic                out_load;
  logic [OP_W-1:0]     op_select;
  logic                done;

  modport master (
    output run, din,
    input  ir_load, r_in, r_out, a_in, g_in, g_out, din_out, out_load,
           op_select, done
  );

  modport slave (
    input  run, din,
    output ir_load, r_in, r_out, a_in, g_in, g_out, din_out, out_load,
           op_select, done
  );

endinterface

// File: rtl/control_unit_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8
// 3-bit binary to 8-bit one-hot decoder with enable; output is all zeros
// when the enable is low.
//   sel_i[2:0]    : binary select
//   en_i          : decoder enable
//   onehot_o[7:0] : one-hot result
// -----------------------------------------------------------------------------
module dec3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign onehot_o[gi] = en_i & (sel_i == 3'(gi));
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Four-step sequencer for a small register-machine datapath. T0 fetches an
// instruction into the IR when run is high; T1..T3 drive the register, ALU
// and bus controls for that instruction and pulse done in its last step.
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   cu     : control_unit_if.slave (run/din in, datapath controls out)
// Step usage:
//   REP  : T1 r_out[Y], r_in[X], done
//   LDI  : T1 din_out, r_in[X], done
//   OUT  : T1 r_out[X], out_load, done
//   ALU  : T1 r_out[X], a_in; T2 r_out[Y], g_in, op; T3 g_out, r_in[X], done
//   undef: T1 done only
// -----------------------------------------------------------------------------
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  control_unit_if.slave  cu
);

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q;

  op_e             ir_op;
  logic [SEL_W-1:0] x_sel;
  logic [SEL_W-1:0] y_sel;

  // Step decode intents; the decoders turn them into one-hot vectors.
  logic rin_x;    // write R[X]
  logic rout_x;   // drive R[X] onto bus
  logic rout_y;   // drive R[Y] onto bus
  logic ir_load;

  logic [NUM_REGS-1:0] x_onehot;
  logic [NUM_REGS-1:0] y_onehot;

  // Upper instruction bits carry no information.
  logic din_hi_unused;
  assign din_hi_unused = ^cu.din[DIN_W-1:IR_W];

  assign ir_op = op_e'(ir_q[OP_MSB:OP_LSB]);
  assign x_sel = ir_q[X_MSB:X_LSB];
  assign y_sel = ir_q[Y_MSB:Y_LSB];

  // ---------------------------------------------------------------------------
  // State and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir_q <= cu.din[IR_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    rin_x        = 1'b0;
    rout_x       = 1'b0;
    rout_y       = 1'b0;
    cu.a_in      = 1'b0;
    cu.g_in      = 1'b0;
    cu.g_out     = 1'b0;
    cu.din_out   = 1'b0;
    cu.out_load  = 1'b0;
    cu.op_select = OP_REP;
    cu.done      = 1'b0;

    unique case (state_q)
      T0: begin
        // resetn gates the fetch so nothing is loaded while reset is held,
        // even though run is otherwise sampled combinationally here.
        ir_load = cu.run & resetn;
        state_d = cu.run ? T1 : T0;
      end

      T1: begin
        state_d = T0;
        unique case (ir_op)
          OP_REP: begin
            rout_y  = 1'b1;
            rin_x   = 1'b1;
            cu.done = 1'b1;
          end
          OP_LDI: begin
            cu.din_out = 1'b1;
            rin_x      = 1'b1;
            cu.done    = 1'b1;
          end
          OP_OUT: begin
            rout_x      = 1'b1;
            cu.out_load = 1'b1;
            cu.done     = 1'b1;
          end
          OP_ADD, OP_SUB, OP_NAN: begin
            rout_x  = 1'b1;
            cu.a_in = 1'b1;
            state_d = T2;
          end
          default: begin
            // Undefined op: retire immediately without touching any register.
            cu.done = 1'b1;
          end
        endcase
      end

      T2: begin
        rout_y       = 1'b1;
        cu.g_in      = 1'b1;
        cu.op_select = ir_op;
        state_d      = T3;
      end

      T3: begin
        cu.g_out = 1'b1;
        rin_x    = 1'b1;
        cu.done  = 1'b1;
        state_d  = T0;
      end

      default: state_d = T0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register select decoders. X is never read and written in the same step,
  // so one X decoder serves both r_in and r_out; r_out[X] and r_out[Y] are
  // likewise never requested together, which keeps the bus single-driven.
  // ---------------------------------------------------------------------------
  dec3to8 u_dec_x (
    .sel_i    (x_sel),
    .en_i     (rin_x | rout_x),
    .onehot_o (x_onehot)
  );

  dec3to8 u_dec_y (
    .sel_i    (y_sel),
    .en_i     (rout_y),
    .onehot_o (y_onehot)
  );

  assign cu.ir_load = ir_load;
  assign cu.r_in    = rin_x  ? x_onehot : '0;
  assign cu.r_out   = rout_x ? x_onehot : y_onehot;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit: reset behaviour, every instruction class,
// back-to-back fetch with run held high, run toggling mid-instruction and a
// reset that aborts an ALU instruction. A monitor checks bus exclusivity and
// one-hot r_in on every falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;
  import control_unit_pkg::*;

  logic clock;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  control_unit_if cu_if ();

  control_unit dut (
    .clock  (clock),
    .resetn (resetn),
    .cu     (cu_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare every control output at once against the expected set.
  task automatic expect_outs(input string tag,
                             input logic       ir_load,
                             input logic [7:0] r_in,
                             input logic [7:0] r_out,
                             input logic       a_in,
                             input logic       g_in,
                             input logic       g_out,
                             input logic       din_out,
                             input logic       out_load,
                             input logic [2:0] op_select,
                             input logic       done);
    logic [25:0] obs;
    logic [25:0] exp;
    #1;
    obs = {cu_if.ir_load, cu_if.r_in, cu_if.r_out, cu_if.a_in, cu_if.g_in,
           cu_if.g_out, cu_if.din_out, cu_if.out_load, cu_if.op_select,
           cu_if.done};
    exp = {ir_load, r_in, r_out, a_in, g_in, g_out, din_out, out_load,
           op_select, done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle: only op_select=REP active.
  task automatic expect_idle(input string tag);
    expect_outs(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b0);
  endtask

  task automatic expect_fetch(input string tag);
    expect_outs(tag, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b0);
  endtask

  // Bus exclusivity and one-hot write enable, every cycle.
  always @(negedge clock) begin
    checks++;
    assert ((int'(cu_if.r_out != 8'h00) + int'(cu_if.g_out) +
             int'(cu_if.din_out)) <= 1 && $countones(cu_if.r_in) <= 1)
    else begin
      failures++;
      $error("FAIL bus_excl observed r_out=%h g_out=%b din_out=%b r_in=%h expected single driver",
             cu_if.r_out, cu_if.g_out, cu_if.din_out, cu_if.r_in);
    end
  end

  initial begin
    // ---- Reset held with run high for three cycles ----
    resetn    = 1'b0;
    cu_if.run = 1'b1;
    cu_if.din = 16'h0168;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("reset_hold");
    end
    $display("reset: held 3 cycles with run=1");

    // ---- LDI R5 (0x0168), immediate 0x00AB ----
    resetn = 1'b1;
    expect_fetch("ldi5_t0");
    tick();
    cu_if.din = 16'h00AB;
    cu_if.run = 1'b0;
    expect_outs("ldi5_t1", 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                3'b111, 1'b1);
    tick();
    expect_idle("ldi5_back_t0");
    tick();
    expect_idle("idle_run0");
    $display("txn: LDI R5 #0x00AB");

    // ---- 0x0148: op 101 with X field 001 -> LDI R1 ----
    cu_if.run = 1'b1;
    cu_if.din = 16'h0148;
    expect_fetch("ldi1_t0");
    tick();
    cu_if.run = 1'b0;
    cu_if.din = 16'h1234;
    expect_outs("ldi1_t1", 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                3'b111, 1'b1);
    $display("txn: LDI R1 #0x1234");

    // ---- ADD R1,R3 (0x000B), run toggled mid-instruction ----
    tick();
    cu_if.run = 1'b1;
    cu_if.din = 16'h000B;
    expect_fetch("add_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("add_t1", 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b0);
    tick();
    cu_if.run = 1'b1;
    cu_if.din = 16'h01FF;
    expect_outs("add_t2", 1'b0, 8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                3'b000, 1'b0);
    tick();
    cu_if.run = 1'b0;
    expect_outs("add_t3", 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                3'b111, 1'b1);
    tick();
    expect_idle("add_back_t0");
    $display("txn: ADD R1,R3");

    // ---- run held high: REP R2,R7 then SUB R0,R1 then fetch NAN R4,R6 ----
    cu_if.run = 1'b1;
    cu_if.din = 16'h01D7;
    expect_fetch("b2b_c1_fetch_rep");
    tick();
    cu_if.din = 16'h0041;
    expect_outs("b2b_c2_rep_t1", 1'b0, 8'h04, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b111, 1'b1);
    $display("txn: REP R2,R7");
    tick();
    expect_fetch("b2b_c3_fetch_sub");
    tick();
    expect_outs("b2b_c4_sub_t1", 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b111, 1'b0);
    tick();
    expect_outs("b2b_c5_sub_t2", 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 3'b001, 1'b0);
    tick();
    cu_if.din = 16'h00A6;
    expect_outs("b2b_c6_sub_t3", 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b0, 3'b111, 1'b1);
    $display("txn: SUB R0,R1");
    tick();
    expect_fetch("nan_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("nan_t1", 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b0);
    tick();
    expect_outs("nan_t2", 1'b0, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                3'b010, 1'b0);

    // ---- reset asserted mid-T2 aborts the NAN ----
    #1;
    resetn    = 1'b0;
    cu_if.run = 1'b1;
    expect_idle("nan_abort_async");
    tick();
    expect_idle("nan_abort_held");
    resetn    = 1'b0;
    cu_if.run = 1'b0;
    tick();
    resetn = 1'b1;
    expect_idle("post_reset_t0");
    tick();
    expect_idle("post_reset_no_rin");
    $display("txn: NAN R4,R6 aborted by reset");

    // ---- ADD R3,R3 (0x001B): X == Y ----
    cu_if.run = 1'b1;
    cu_if.din = 16'h001B;
    expect_fetch("add33_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("add33_t1", 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b0);
    tick();
    expect_outs("add33_t2", 1'b0, 8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                3'b000, 1'b0);
    tick();
    expect_outs("add33_t3", 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                3'b111, 1'b1);
    $display("txn: ADD R3,R3");

    // ---- OUT R2 (0x0110) ----
    tick();
    cu_if.run = 1'b1;
    cu_if.din = 16'h0110;
    expect_fetch("out_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("out_t1", 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                3'b111, 1'b1);
    $display("txn: OUT R2");

    // ---- Undefined op 011 (0x00C0) ----
    tick();
    cu_if.run = 1'b1;
    cu_if.din = 16'h00C0;
    expect_fetch("ud3_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("ud3_t1", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b1);
    tick();
    expect_idle("ud3_back_t0");
    $display("txn: undefined op 011");

    // ---- Undefined op 110 (0x01BF, nonzero X/Y fields) ----
    cu_if.run = 1'b1;
    cu_if.din = 16'h01BF;
    expect_fetch("ud6_t0");
    tick();
    cu_if.run = 1'b0;
    expect_outs("ud6_t1", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b111, 1'b1);
    tick();
    expect_idle("ud6_back_t0");
    $display("txn: undefined op 110");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
